servo_pwm_capture: RTL

SERVO_PWM_CAPTURE -- requirements
Module: servo_pwm_capture

---
 rtl/servo_pwm_capture.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/servo_pwm_capture.sv
// Servo PWM capture: measures high time and rise-to-rise period of an
// asynchronous PWM input in microseconds, with range and timeout flags.
module servo_pwm_capture #(
  parameter int TICKS_PER_US = 50,
  parameter int MIN_PULSE_US = 500,
  parameter int MAX_PULSE_US = 2500,
  parameter int TIMEOUT_US   = 25000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pwm_in,
  output logic [15:0] pulse_us,
  output logic [15:0] period_us,
  output logic        pulse_valid,
  output logic        err_range,
  output logic        err_timeout,
  output logic        signal_lost
);

  // state | meaning
  // SYNC  | not tracking; wait for a rising edge to start a measurement
  // HIGH  | input high; width_cnt accumulating
  // LOW   | width latched; waiting for the next rise to publish
  typedef enum logic [1:0] {ST_SYNC, ST_HIGH, ST_LOW} state_t;

  localparam int PW = (TICKS_PER_US > 1) ? $clog2(TICKS_PER_US) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICKS_PER_US - 1);
  localparam logic [15:0]   MIN_US   = 16'(MIN_PULSE_US);
  localparam logic [15:0]   MAX_US   = 16'(MAX_PULSE_US);
  localparam logic [15:0]   TO_LAST  = 16'(TIMEOUT_US - 1);

  state_t r_state, w_state_nxt;

  logic          r_sync1, r_sync2, r_hist;
  logic [1:0]    r_arm_cnt;
  logic          r_rise, r_fall;
  logic [PW-1:0] r_presc;
  logic [15:0]   r_width_cnt, r_per_cnt, r_width;

  logic          w_armed, w_tick, w_timeout, w_publish, w_latch;
  logic [15:0]   w_width_nxt, w_per_nxt;

  // Edges are only trusted once the whole chain holds real samples, so a
  // pulse already high when reset releases is never seen as a rise.
  assign w_armed = (r_arm_cnt == 2'd3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_hist    <= 1'b0;
      r_arm_cnt <= 2'd0;
      r_rise    <= 1'b0;
      r_fall    <= 1'b0;
    end else begin
      r_sync1 <= pwm_in;
      r_sync2 <= r_sync1;
      r_hist  <= r_sync2;
      if (!w_armed) r_arm_cnt <= r_arm_cnt + 2'd1;
      r_rise  <= w_armed &  r_sync2 & ~r_hist;
      r_fall  <= w_armed & ~r_sync2 &  r_hist;
    end
  end

  assign w_tick = (r_presc == PRE_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_presc <= '0;
    else if (r_rise) r_presc <= '0;
    else if (w_tick) r_presc <= '0;
    else             r_presc <= r_presc + 1'b1;
  end

  // Next values include this cycle's tick so a latch or publish sees a
  // whole number of completed microseconds.
  always_comb begin
    w_per_nxt   = r_per_cnt;
    w_width_nxt = r_width_cnt;
    if (w_tick && r_per_cnt != 16'hFFFF) w_per_nxt = r_per_cnt + 16'd1;
    if (w_tick && r_state == ST_HIGH && r_width_cnt != 16'hFFFF)
      w_width_nxt = r_width_cnt + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_per_cnt   <= 16'd0;
      r_width_cnt <= 16'd0;
    end else if (r_rise) begin
      r_per_cnt   <= 16'd0;
      r_width_cnt <= 16'd0;
    end else begin
      r_per_cnt   <= w_per_nxt;
      r_width_cnt <= w_width_nxt;
    end
  end

  assign w_timeout = (r_state != ST_SYNC) && w_tick && (r_per_cnt == TO_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_SYNC;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_publish   = 1'b0;
    w_latch     = 1'b0;
    case (r_state)
      ST_SYNC: if (r_rise) w_state_nxt = ST_HIGH;
      ST_HIGH: begin
        if (w_timeout) begin
          w_state_nxt = ST_SYNC;
        end else if (r_fall) begin
          w_latch     = 1'b1;
          w_state_nxt = ST_LOW;
        end
      end
      ST_LOW: begin
        if (w_timeout) begin
          w_state_nxt = ST_SYNC;
        end else if (r_rise) begin
          w_publish   = 1'b1;
          w_state_nxt = ST_HIGH;
        end
      end
      default: w_state_nxt = ST_SYNC;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_width     <= 16'd0;
      pulse_us    <= 16'd0;
      period_us   <= 16'd0;
      pulse_valid <= 1'b0;
      err_range   <= 1'b0;
      err_timeout <= 1'b0;
      signal_lost <= 1'b1;
    end else begin
      if (w_latch) r_width <= w_width_nxt;
      pulse_valid <= w_publish;
      err_range   <= w_publish && ((r_width < MIN_US) || (r_width > MAX_US));
      err_timeout <= w_timeout;
      if (w_publish) begin
        pulse_us  <= r_width;
        period_us <= w_per_nxt;
      end
      if (w_timeout)      signal_lost <= 1'b1;
      else if (w_publish) signal_lost <= 1'b0;
    end
  end

endmodule
